// File: rtl/id_fwd_stage.sv
// Instruction-decode stage: field extraction, operand forwarding, load-use stall, registered ID/EX.
// Define ID_BRANCH_RESOLVE_EN to resolve branches/jumps here and redirect fetch.
module id_fwd_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned FWD_PORTS = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned SEL_W     = $clog2(FWD_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_W-1:0]           inst_addr,
    input  logic [31:0]                 inst,
    input  logic                        reg_rt,
    input  logic                        jump,
    input  logic                        branch,
    input  logic                        branch_ne,
    input  logic                        sext_signed,
    input  logic                        uses_rt,
    input  logic [FWD_PORTS*DATA_W-1:0] fwd_data_a,
    input  logic [FWD_PORTS*DATA_W-1:0] fwd_data_b,
    input  logic [SEL_W-1:0]            fwd_sel_a,
    input  logic [SEL_W-1:0]            fwd_sel_b,
    input  logic                        ex_load_pending,
    input  logic [4:0]                  ex_load_rd,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [5:0]                  opcode,
    output logic [5:0]                  func,
    output logic [4:0]                  rs,
    output logic [4:0]                  rt,
    output logic [4:0]                  reg_des,
    output logic [DATA_W-1:0]           imm_ext,
    output logic [DATA_W-1:0]           op1,
    output logic [DATA_W-1:0]           op2,
    output logic                        redirect_valid,
    output logic [ADDR_W-1:0]           redirect_addr,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam logic [1:0] StRun = 2'd0;
    localparam logic [1:0] StHaz = 2'd1;
`ifdef ID_BRANCH_RESOLVE_EN
    localparam logic [1:0] StRdr = 2'd2;
`endif

    logic [1:0]        state_q, state_d;
    logic              hazard, accept, in_rdr;
    logic [DATA_W-1:0] op_a_sel, op_b_sel, imm_d;

    assign hazard = in_valid & ex_load_pending & (ex_load_rd != 5'd0) &
                    ((ex_load_rd == inst[25:21]) | (uses_rt & (ex_load_rd == inst[20:16])));

    assign in_ready = in_rdr | (!flush & !hazard & (!out_valid | out_ready));
    // Beats arriving in RDR are wrong-path and are swallowed, never accepted.
    assign accept   = in_valid & in_ready & !in_rdr;

    assign imm_d = sext_signed ? DATA_W'($signed(inst[15:0])) : DATA_W'(inst[15:0]);

    // Out-of-range selects fall back to the register-file slot.
    always_comb begin
        op_a_sel = fwd_data_a[DATA_W-1:0];
        op_b_sel = fwd_data_b[DATA_W-1:0];
        for (int i = 1; i < int'(FWD_PORTS); i++) begin
            if (int'(fwd_sel_a) == i) op_a_sel = fwd_data_a[i*DATA_W +: DATA_W];
            if (int'(fwd_sel_b) == i) op_b_sel = fwd_data_b[i*DATA_W +: DATA_W];
        end
    end

`ifdef ID_BRANCH_RESOLVE_EN
    logic              taken, redirect_fire;
    logic [ADDR_W-1:0] pc4, jump_tgt, br_tgt;

    assign in_rdr        = (state_q == StRdr);
    assign pc4           = inst_addr + ADDR_W'(4);
    assign jump_tgt      = (pc4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({inst[25:0], 2'b00});
    assign br_tgt        = pc4 + ADDR_W'($signed({inst[15:0], 2'b00}));
    assign taken         = jump | (branch & ((op_a_sel == op_b_sel) ^ branch_ne));
    assign redirect_fire = accept & taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
        end else begin
            redirect_valid <= redirect_fire;
            if (redirect_fire) redirect_addr <= jump ? jump_tgt : br_tgt;
        end
    end
`else
    logic unused_branch_inputs;

    assign in_rdr               = 1'b0;
    assign redirect_valid       = 1'b0;
    assign redirect_addr        = '0;
    assign unused_branch_inputs = ^{jump, branch, branch_ne, inst_addr};
`endif

    always_comb begin
        state_d = StRun;
        if (flush) begin
            state_d = StRun;
        end else if (accept) begin
`ifdef ID_BRANCH_RESOLVE_EN
            state_d = redirect_fire ? StRdr : StRun;
`else
            state_d = StRun;
`endif
        end else if (in_rdr) begin
            state_d = StRun;
        end else begin
            state_d = hazard ? StHaz : StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            out_valid <= 1'b0;
            opcode    <= '0;
            func      <= '0;
            rs        <= '0;
            rt        <= '0;
            reg_des   <= '0;
            imm_ext   <= '0;
            op1       <= '0;
            op2       <= '0;
            stall_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == StHaz && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                opcode    <= inst[31:26];
                func      <= inst[5:0];
                rs        <= inst[25:21];
                rt        <= inst[20:16];
                reg_des   <= reg_rt ? inst[20:16] : inst[15:11];
                imm_ext   <= imm_d;
                op1       <= op_a_sel;
                op2       <= op_b_sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed self-checking bench for id_fwd_stage; expectations follow ID_BRANCH_RESOLVE_EN.
module tb_id_fwd_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned NP = 5;
    localparam int unsigned CW = 3;
    localparam int unsigned SW = $clog2(NP);
`ifdef ID_BRANCH_RESOLVE_EN
    localparam bit BrEn = 1'b1;
`else
    localparam bit BrEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid, in_ready, reg_rt, jump, branch, branch_ne, sext_signed, uses_rt;
    logic [AW-1:0]    inst_addr;
    logic [31:0]      inst;
    logic [NP*DW-1:0] fwd_data_a, fwd_data_b;
    logic [SW-1:0]    fwd_sel_a, fwd_sel_b;
    logic             ex_load_pending, flush, out_valid, out_ready, redirect_valid;
    logic [4:0]       ex_load_rd, rs, rt, reg_des;
    logic [5:0]       opcode, func;
    logic [DW-1:0]    imm_ext, op1, op2;
    logic [AW-1:0]    redirect_addr;
    logic [CW-1:0]    stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_fwd_stage #(.DATA_W(DW), .ADDR_W(AW), .FWD_PORTS(NP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inst_addr(inst_addr), .inst(inst), .reg_rt(reg_rt), .jump(jump), .branch(branch),
        .branch_ne(branch_ne), .sext_signed(sext_signed), .uses_rt(uses_rt),
        .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b), .fwd_sel_a(fwd_sel_a),
        .fwd_sel_b(fwd_sel_b), .ex_load_pending(ex_load_pending), .ex_load_rd(ex_load_rd),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
        .func(func), .rs(rs), .rt(rt), .reg_des(reg_des), .imm_ext(imm_ext), .op1(op1),
        .op2(op2), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 0; inst_addr = '0; inst = '0; reg_rt = 0; jump = 0; branch = 0;
        branch_ne = 0; sext_signed = 0; uses_rt = 0; fwd_sel_a = '0; fwd_sel_b = '0;
        ex_load_pending = 0; ex_load_rd = '0; flush = 0; out_ready = 1;
        for (int i = 0; i < int'(NP); i++) begin
            fwd_data_a[i*DW +: DW] = 32'hA000_0000 + i;
            fwd_data_b[i*DW +: DW] = 32'hB000_0000 + i;
        end
        #2 rst_n = 0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h want=0", out_valid); end
        checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL reset_stall_cnt got=%0h want=0", stall_cnt); end
        checks++; if ({op1, imm_ext, reg_des, redirect_valid} !== '0) begin failures++; $display("FAIL reset_fields got=%0h want=0", {op1, imm_ext, reg_des, redirect_valid}); end
        rst_n = 1;
    endtask

    task automatic test_decode();
        in_valid = 1; inst = 32'h2008_FFFF; reg_rt = 1; sext_signed = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL decode_in_ready got=%0h want=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL decode_out_valid got=%0h want=1", out_valid); end
        checks++; if (imm_ext !== 32'hFFFF_FFFF) begin failures++; $display("FAIL decode_sext got=%0h want=ffffffff", imm_ext); end
        checks++; if (reg_des !== 5'd8) begin failures++; $display("FAIL decode_reg_des_rt got=%0h want=8", reg_des); end
        checks++; if (opcode !== 6'h08) begin failures++; $display("FAIL decode_opcode got=%0h want=8", opcode); end
        sext_signed = 0;
        tick();
        checks++; if (imm_ext !== 32'h0000_FFFF) begin failures++; $display("FAIL decode_zext got=%0h want=ffff", imm_ext); end
        inst = 32'h0022_1820; reg_rt = 0;
        tick();
        checks++; if (reg_des !== 5'd3) begin failures++; $display("FAIL decode_reg_des_rd got=%0h want=3", reg_des); end
        checks++; if ({rs, rt, func} !== {5'd1, 5'd2, 6'h20}) begin failures++; $display("FAIL decode_rtype got=%0h want=%0h", {rs, rt, func}, {5'd1, 5'd2, 6'h20}); end
        in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL decode_bubble got=%0h want=0", out_valid); end
    endtask

    task automatic test_forward();
        fwd_data_a[2*DW +: DW] = 32'hDEAD_BEEF;
        in_valid = 1; inst = 32'h0022_1820; fwd_sel_a = 3'd2; fwd_sel_b = 3'd7;
        tick();
        checks++; if (op1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fwd_sel_a2 got=%0h want=deadbeef", op1); end
        checks++; if (op2 !== 32'hB000_0000) begin failures++; $display("FAIL fwd_sel_b7 got=%0h want=b0000000", op2); end
        fwd_sel_a = 3'd4; fwd_sel_b = 3'd5;
        tick();
        checks++; if (op1 !== 32'hA000_0004) begin failures++; $display("FAIL fwd_sel_a4 got=%0h want=a0000004", op1); end
        checks++; if (op2 !== 32'hB000_0000) begin failures++; $display("FAIL fwd_sel_b5 got=%0h want=b0000000", op2); end
        fwd_sel_a = '0; fwd_sel_b = '0;
    endtask

    task automatic test_hazard();
        inst = 32'h00A6_1820; ex_load_pending = 1; ex_load_rd = 5'd5;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hazard_in_ready cyc=%0d got=%0h want=0", c, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hazard_bubble cyc=%0d got=%0h want=0", c, out_valid); end
        end
        ex_load_pending = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hazard_release got=%0h want=1", in_ready); end
        tick();
        checks++; if (stall_cnt !== 3'd3) begin failures++; $display("FAIL hazard_stall_cnt got=%0h want=3", stall_cnt); end
        checks++; if ({out_valid, rs} !== {1'b1, 5'd5}) begin failures++; $display("FAIL hazard_accept got=%0h want=%0h", {out_valid, rs}, {1'b1, 5'd5}); end
        ex_load_pending = 1; ex_load_rd = 5'd6; uses_rt = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hazard_rt got=%0h want=0", in_ready); end
        uses_rt = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hazard_rt_unused got=%0h want=1", in_ready); end
        ex_load_rd = 5'd0; inst = 32'h0000_1820; uses_rt = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hazard_r0 got=%0h want=1", in_ready); end
        ex_load_rd = 5'd5; inst = 32'h00A6_1820;
        for (int c = 0; c < 9; c++) tick();
        checks++; if (stall_cnt !== 3'd7) begin failures++; $display("FAIL hazard_saturate got=%0h want=7", stall_cnt); end
        ex_load_pending = 0; uses_rt = 0;
        tick();
    endtask

    task automatic test_branch();
        fwd_data_b[DW-1:0] = 32'hA000_0000;
        inst = 32'h1022_0003; inst_addr = 32'h0040_0010; branch = 1; branch_ne = 0; uses_rt = 1;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL beq_out_valid got=%0h want=1", out_valid); end
        checks++; if (redirect_valid !== BrEn) begin failures++; $display("FAIL beq_redirect_valid got=%0h want=%0h", redirect_valid, BrEn); end
        checks++; if (redirect_addr !== (BrEn ? 32'h0040_0020 : 32'h0)) begin failures++; $display("FAIL beq_redirect_addr got=%0h want=%0h", redirect_addr, BrEn ? 32'h0040_0020 : 32'h0); end
        inst = 32'h0022_1820; branch = 0; uses_rt = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL beq_next_ready got=%0h want=1", in_ready); end
        tick();
        checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL beq_pulse got=%0h want=0", redirect_valid); end
        checks++; if (out_valid !== !BrEn) begin failures++; $display("FAIL beq_discard got=%0h want=%0h", out_valid, !BrEn); end
        inst = 32'h1422_0003; branch = 1; branch_ne = 1;
        tick();
        checks++; if ({out_valid, opcode, redirect_valid} !== {1'b1, 6'h05, 1'b0}) begin failures++; $display("FAIL bne_equal got=%0h want=%0h", {out_valid, opcode, redirect_valid}, {1'b1, 6'h05, 1'b0}); end
        inst = 32'h1022_0003; branch_ne = 0; fwd_sel_b = 3'd1;
        tick();
        checks++; if ({out_valid, redirect_valid} !== 2'b10) begin failures++; $display("FAIL beq_unequal got=%0h want=2", {out_valid, redirect_valid}); end
        branch = 0; fwd_sel_b = '0;
    endtask

    task automatic test_jump();
        inst = 32'h0800_0100; inst_addr = 32'h1000_0000; jump = 1;
        tick();
        checks++; if (redirect_valid !== BrEn) begin failures++; $display("FAIL jump_redirect_valid got=%0h want=%0h", redirect_valid, BrEn); end
        checks++; if (redirect_addr !== (BrEn ? 32'h1000_0400 : 32'h0)) begin failures++; $display("FAIL jump_redirect_addr got=%0h want=%0h", redirect_addr, BrEn ? 32'h1000_0400 : 32'h0); end
        in_valid = 0;
        tick();
        checks++; if ({out_valid, redirect_valid} !== 2'b00) begin failures++; $display("FAIL jump_pulse got=%0h want=0", {out_valid, redirect_valid}); end
        in_valid = 1; flush = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0h want=0", in_ready); end
        tick();
        checks++; if ({out_valid, redirect_valid} !== 2'b00) begin failures++; $display("FAIL flush_jump got=%0h want=0", {out_valid, redirect_valid}); end
        flush = 0; jump = 0; in_valid = 0;
        tick();
    endtask

    task automatic test_hold_and_reset();
        in_valid = 1; inst = 32'h0022_1820; fwd_sel_a = 3'd2; reg_rt = 0;
        tick();
        out_ready = 0; inst = 32'h2008_FFFF; reg_rt = 1; fwd_sel_a = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%0h want=0", c, in_ready); end
            tick();
            checks++; if ({out_valid, func, op1} !== {1'b1, 6'h20, 32'hDEAD_BEEF}) begin failures++; $display("FAIL hold_stable cyc=%0d got=%0h want=%0h", c, {out_valid, func, op1}, {1'b1, 6'h20, 32'hDEAD_BEEF}); end
        end
        #3 rst_n = 0;
        #1;
        checks++; if ({out_valid, func, op1, reg_des, stall_cnt} !== '0) begin failures++; $display("FAIL async_reset got=%0h want=0", {out_valid, func, op1, reg_des, stall_cnt}); end
        tick();
        rst_n = 1; out_ready = 1; sext_signed = 1;
        tick();
        checks++; if ({out_valid, imm_ext} !== {1'b1, 32'hFFFF_FFFF}) begin failures++; $display("FAIL first_accept got=%0h want=%0h", {out_valid, imm_ext}, {1'b1, 32'hFFFF_FFFF}); end
        in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_forward();
        test_hazard();
        test_branch();
        test_jump();
        test_hold_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
